// File: rtl/cp0_regfile_if.sv
// ---------------------------------------------------------------------------
// cp0_regfile_if
// MTC0 / MFC0 access bus between the pipeline and the CP0 register file.
//   WE     : MTC0 write enable
//   WAddr  : MTC0 register number      WSel : MTC0 select
//   WData  : MTC0 write data
//   RAddr  : MFC0 register number      RSel : MFC0 select
//   RData  : MFC0 read data (driven by the register file)
// master = pipeline side, slave = register file side.
// ---------------------------------------------------------------------------
interface cp0_regfile_if;
  logic        WE;
  logic [4:0]  WAddr;
  logic [2:0]  WSel;
  logic [31:0] WData;
  logic [4:0]  RAddr;
  logic [2:0]  RSel;
  logic [31:0] RData;

  modport master (
    output WE, WAddr, WSel, WData, RAddr, RSel,
    input  RData
  );

  modport slave (
    input  WE, WAddr, WSel, WData, RAddr, RSel,
    output RData
  );
endinterface

// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
// MIPS32 coprocessor-0 register file: Count, Compare, Status, Cause, EPC,
// EBase and a constant PRId. Services MTC0/MFC0, records exception entry and
// ERET, latches hardware/timer interrupt requests.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   bus              : MTC0/MFC0 access (cp0_regfile_if.slave)
//   HwInt[5:0]       : hardware interrupt lines, sampled into Cause.IP[7:2]
//   ExcValid/ExcCode/ExcInstPC/ExcDelay : exception entry
//   EretValid        : ERET commit
//   CP0EBASE/STATUS/CAUSE/EPC/COUNT/COMPARE : current register contents
//   IntPending       : enabled interrupt pending and not masked by EXL/IE
// ---------------------------------------------------------------------------
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE  = 32'h0001_8000,
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  cp0_regfile_if.slave bus,
  input  logic [5:0]  HwInt,
  input  logic        ExcValid,
  input  logic [4:0]  ExcCode,
  input  logic [31:0] ExcInstPC,
  input  logic        ExcDelay,
  input  logic        EretValid,
  output logic [31:0] CP0EBASE,
  output logic [31:0] CP0STATUS,
  output logic [31:0] CP0CAUSE,
  output logic [31:0] CP0EPC,
  output logic [31:0] CP0COUNT,
  output logic [31:0] CP0COMPARE,
  output logic        IntPending
);

  // {register number, select} encodings of the mapped registers
  localparam logic [7:0] SEL_COUNT   = {5'd9,  3'd0};
  localparam logic [7:0] SEL_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] SEL_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] SEL_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] SEL_EPC     = {5'd14, 3'd0};
  localparam logic [7:0] SEL_PRID    = {5'd15, 3'd0};
  localparam logic [7:0] SEL_EBASE   = {5'd15, 3'd1};

  // Only the architecturally writable fields are stored.
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_pend_q, timer_pend_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [17:0] ebase_q, ebase_d;

  logic [7:0]  wsel_s;
  logic [7:0]  rsel_s;
  logic        mtc0_s;
  logic        wr_count_s, wr_compare_s, wr_status_s, wr_cause_s, wr_epc_s, wr_ebase_s;
  logic [31:0] status_s, cause_s, ebase_s;

  assign wsel_s = {bus.WAddr, bus.WSel};
  assign rsel_s = {bus.RAddr, bus.RSel};

  // An exception in the same cycle swallows the MTC0 write.
  assign mtc0_s       = bus.WE & ~ExcValid;
  assign wr_count_s   = mtc0_s & (wsel_s == SEL_COUNT);
  assign wr_compare_s = mtc0_s & (wsel_s == SEL_COMPARE);
  assign wr_status_s  = mtc0_s & (wsel_s == SEL_STATUS);
  assign wr_cause_s   = mtc0_s & (wsel_s == SEL_CAUSE);
  assign wr_epc_s     = mtc0_s & (wsel_s == SEL_EPC);
  assign wr_ebase_s   = mtc0_s & (wsel_s == SEL_EBASE);

  assign status_s = {16'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_s  = {bd_q, 15'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'd0};
  assign ebase_s  = {1'b1, 1'b0, ebase_q, 12'd0};

  // Next-state computation for every CP0 field
  always_comb begin
    if (wr_count_s) count_d = bus.WData;
    else            count_d = count_q + 32'd1;

    if (wr_compare_s) compare_d = bus.WData;
    else              compare_d = compare_q;

    // Clear from a Compare write wins over a coincident match.
    if (wr_compare_s)                timer_pend_d = 1'b0;
    else if (count_d == compare_q)   timer_pend_d = 1'b1;
    else                             timer_pend_d = timer_pend_q;

    if (wr_status_s) begin
      im_d = bus.WData[15:8];
      ie_d = bus.WData[0];
    end else begin
      im_d = im_q;
      ie_d = ie_q;
    end

    // EXL: exception sets, ERET clears (overriding a same-cycle MTC0 value).
    if (ExcValid)          exl_d = 1'b1;
    else if (EretValid)    exl_d = 1'b0;
    else if (wr_status_s)  exl_d = bus.WData[1];
    else                   exl_d = exl_q;

    // IP7 also carries the timer request latched on the previous edge.
    ip_hw_d = {HwInt[5] | timer_pend_q, HwInt[4:0]};

    if (wr_cause_s) ip_sw_d = bus.WData[9:8];
    else            ip_sw_d = ip_sw_q;

    if (ExcValid) exccode_d = ExcCode;
    else          exccode_d = exccode_q;

    // Nested exceptions (EXL already set) keep the original EPC and BD.
    if (ExcValid && !exl_q) begin
      bd_d  = ExcDelay;
      epc_d = ExcDelay ? (ExcInstPC - 32'd4) : ExcInstPC;
    end else if (wr_epc_s) begin
      bd_d  = bd_q;
      epc_d = bus.WData;
    end else begin
      bd_d  = bd_q;
      epc_d = epc_q;
    end

    if (wr_ebase_s) ebase_d = bus.WData[29:12];
    else            ebase_d = ebase_q;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= 32'd0;
      compare_q    <= 32'd0;
      timer_pend_q <= 1'b0;
      im_q         <= 8'd0;
      exl_q        <= 1'b0;
      ie_q         <= 1'b0;
      bd_q         <= 1'b0;
      ip_hw_q      <= 6'd0;
      ip_sw_q      <= 2'd0;
      exccode_q    <= 5'd0;
      epc_q        <= 32'd0;
      ebase_q      <= EBASE_RESET[29:12];
    end else begin
      count_q      <= count_d;
      compare_q    <= compare_d;
      timer_pend_q <= timer_pend_d;
      im_q         <= im_d;
      exl_q        <= exl_d;
      ie_q         <= ie_d;
      bd_q         <= bd_d;
      ip_hw_q      <= ip_hw_d;
      ip_sw_q      <= ip_sw_d;
      exccode_q    <= exccode_d;
      epc_q        <= epc_d;
      ebase_q      <= ebase_d;
    end
  end

  // MFC0 read mux: current state only, no bypass of a same-cycle write
  always_comb begin
    case (rsel_s)
      SEL_COUNT:   bus.RData = count_q;
      SEL_COMPARE: bus.RData = compare_q;
      SEL_STATUS:  bus.RData = status_s;
      SEL_CAUSE:   bus.RData = cause_s;
      SEL_EPC:     bus.RData = epc_q;
      SEL_PRID:    bus.RData = PRID_VALUE;
      SEL_EBASE:   bus.RData = ebase_s;
      default:     bus.RData = 32'd0;
    endcase
  end

  assign CP0EBASE   = ebase_s;
  assign CP0STATUS  = status_s;
  assign CP0CAUSE   = cause_s;
  assign CP0EPC     = epc_q;
  assign CP0COUNT   = count_q;
  assign CP0COMPARE = compare_q;
  assign IntPending = (|({ip_hw_q, ip_sw_q} & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// ---------------------------------------------------------------------------
// tb_cp0_regfile
// Directed scenarios plus randomized traffic against a word-level reference
// model of the CP0 registers.
// ---------------------------------------------------------------------------
module tb_cp0_regfile;
  logic        clk;
  logic        rst;
  logic [5:0]  HwInt;
  logic        ExcValid;
  logic [4:0]  ExcCode;
  logic [31:0] ExcInstPC;
  logic        ExcDelay;
  logic        EretValid;
  logic [31:0] CP0EBASE, CP0STATUS, CP0CAUSE, CP0EPC, CP0COUNT, CP0COMPARE;
  logic        IntPending;

  int checks;
  int errors;

  // reference model state: whole architectural words
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_ebase;
  logic        m_tp;

  cp0_regfile_if bus ();

  cp0_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .HwInt      (HwInt),
    .ExcValid   (ExcValid),
    .ExcCode    (ExcCode),
    .ExcInstPC  (ExcInstPC),
    .ExcDelay   (ExcDelay),
    .EretValid  (EretValid),
    .CP0EBASE   (CP0EBASE),
    .CP0STATUS  (CP0STATUS),
    .CP0CAUSE   (CP0CAUSE),
    .CP0EPC     (CP0EPC),
    .CP0COUNT   (CP0COUNT),
    .CP0COMPARE (CP0COMPARE),
    .IntPending (IntPending)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 32'd0; m_compare = 32'd0; m_status = 32'd0; m_cause = 32'd0;
    m_epc = 32'd0; m_ebase = 32'h8000_0000; m_tp = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra, input logic [2:0] rs);
    case ({ra, rs})
      {5'd9,  3'd0}: return m_count;
      {5'd11, 3'd0}: return m_compare;
      {5'd12, 3'd0}: return m_status;
      {5'd13, 3'd0}: return m_cause;
      {5'd14, 3'd0}: return m_epc;
      {5'd15, 3'd0}: return 32'h0001_8000;
      {5'd15, 3'd1}: return m_ebase;
      default:       return 32'd0;
    endcase
  endfunction

  // advance the model by one clock edge using the current inputs
  task automatic model_step();
    logic [31:0] count_n, compare_n, status_n, cause_n, epc_n, ebase_n;
    logic        tp_n, mtc0;
    count_n = m_count + 32'd1; compare_n = m_compare; status_n = m_status;
    cause_n = m_cause; epc_n = m_epc; ebase_n = m_ebase; tp_n = m_tp;
    mtc0 = bus.WE && !ExcValid;
    if (mtc0) begin
      case ({bus.WAddr, bus.WSel})
        {5'd9,  3'd0}: count_n = bus.WData;
        {5'd11, 3'd0}: compare_n = bus.WData;
        {5'd12, 3'd0}: status_n = bus.WData & 32'h0000_FF03;
        {5'd13, 3'd0}: cause_n = (m_cause & ~32'h0000_0300) | (bus.WData & 32'h0000_0300);
        {5'd14, 3'd0}: epc_n = bus.WData;
        {5'd15, 3'd1}: ebase_n = 32'h8000_0000 | (bus.WData & 32'h3FFF_F000);
        default: ;
      endcase
    end
    if (EretValid && !ExcValid) status_n[1] = 1'b0;
    if (ExcValid) begin
      if (!m_status[1]) begin
        epc_n = ExcDelay ? ExcInstPC - 32'd4 : ExcInstPC;
        cause_n[31] = ExcDelay;
      end
      cause_n[6:2] = ExcCode;
      status_n[1] = 1'b1;
    end
    if (count_n == m_compare) tp_n = 1'b1;
    if (mtc0 && bus.WAddr == 5'd11 && bus.WSel == 3'd0) tp_n = 1'b0;
    cause_n[15:10] = {HwInt[5] | m_tp, HwInt[4:0]};
    m_count = count_n; m_compare = compare_n; m_status = status_n; m_cause = cause_n;
    m_epc = epc_n; m_ebase = ebase_n; m_tp = tp_n;
  endtask

  task automatic compare_all();
    logic ip;
    ip = ((m_cause & m_status & 32'h0000_FF00) != 32'd0) && m_status[0] && !m_status[1];
    check_val("count",   CP0COUNT,   m_count);
    check_val("compare", CP0COMPARE, m_compare);
    check_val("status",  CP0STATUS,  m_status);
    check_val("cause",   CP0CAUSE,   m_cause);
    check_val("epc",     CP0EPC,     m_epc);
    check_val("ebase",   CP0EBASE,   m_ebase);
    check_val("rdata",   bus.RData,  model_read(bus.RAddr, bus.RSel));
    check_val("intpend", {31'd0, IntPending}, {31'd0, ip});
  endtask

  task automatic idle();
    bus.WE = 1'b0; bus.WAddr = 5'd0; bus.WSel = 3'd0; bus.WData = 32'd0;
    bus.RAddr = 5'd0; bus.RSel = 3'd0; HwInt = 6'd0; ExcValid = 1'b0;
    ExcCode = 5'd0; ExcInstPC = 32'd0; ExcDelay = 1'b0; EretValid = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.WE = 1'b1; bus.WAddr = a; bus.WSel = s; bus.WData = d;
  endtask

  // called at a falling edge with inputs already driven
  task automatic tick();
    #1;
    compare_all();
    model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] atab [7];
    logic [2:0] stab [7];
    int k;
    atab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd15};
    stab = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    checks = 0;
    errors = 0;

    // reset held, then released
    rst = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compare_all();
    rst = 1'b1;
    tick();
    check_val("count_after_reset", CP0COUNT, 32'd1);

    // writable masks
    idle(); mtc0(5'd12, 3'd0, 32'hFFFF_FFFF); tick();
    idle(); bus.RAddr = 5'd12; #1;
    check_val("mfc0_status", bus.RData, 32'h0000_FF03);
    tick();
    idle(); mtc0(5'd15, 3'd1, 32'hFFFF_FFFF); bus.RAddr = 5'd15; bus.RSel = 3'd1; #1;
    check_val("mfc0_ebase_old", bus.RData, 32'h8000_0000);
    tick();
    idle(); bus.RAddr = 5'd15; bus.RSel = 3'd1; #1;
    check_val("mfc0_ebase", bus.RData, 32'hBFFF_F000);
    tick();

    // exception in delay slot, nested exception, ERET
    idle(); mtc0(5'd12, 3'd0, 32'd0); tick();
    idle(); ExcValid = 1'b1; ExcDelay = 1'b1; ExcInstPC = 32'h8000_0104; ExcCode = 5'b01000; tick();
    check_val("exc_epc", CP0EPC, 32'h8000_0100);
    check_val("exc_bd", {31'd0, CP0CAUSE[31]}, 32'd1);
    check_val("exc_code", {27'd0, CP0CAUSE[6:2]}, 32'd8);
    check_val("exc_exl", {31'd0, CP0STATUS[1]}, 32'd1);
    idle(); ExcValid = 1'b1; ExcInstPC = 32'h9000_0000; ExcCode = 5'b00000; tick();
    check_val("nested_epc", CP0EPC, 32'h8000_0100);
    idle(); EretValid = 1'b1; tick();
    check_val("eret_exl", {31'd0, CP0STATUS[1]}, 32'd0);

    // hardware interrupt and EXL masking
    idle(); mtc0(5'd12, 3'd0, 32'h0000_1001); HwInt = 6'b000100; tick();
    idle(); HwInt = 6'b000100; #1;
    check_val("hw_ip2", {31'd0, CP0CAUSE[12]}, 32'd1);
    check_val("hw_intpend", {31'd0, IntPending}, 32'd1);
    mtc0(5'd12, 3'd0, 32'h0000_1003); tick();
    check_val("exl_masks", {31'd0, IntPending}, 32'd0);

    // Count wrap and timer interrupt
    idle(); mtc0(5'd9, 3'd0, 32'hFFFF_FFFD); tick();
    idle(); mtc0(5'd11, 3'd0, 32'h0000_0001); tick();
    idle(); tick();
    check_val("count_ffffffff", CP0COUNT, 32'hFFFF_FFFF);
    tick();
    check_val("count_wrap", CP0COUNT, 32'd0);
    tick();
    check_val("count_eq_cmp", CP0COUNT, 32'd1);
    check_val("timer_not_yet", {31'd0, CP0CAUSE[15]}, 32'd0);
    tick();
    check_val("timer_ip7", {31'd0, CP0CAUSE[15]}, 32'd1);
    idle(); mtc0(5'd11, 3'd0, 32'h0000_0100); tick();
    idle(); tick();
    check_val("timer_cleared", {31'd0, CP0CAUSE[15]}, 32'd0);

    // exception overrides a same-cycle MTC0
    idle(); mtc0(5'd12, 3'd0, 32'd0); tick();
    idle(); mtc0(5'd14, 3'd0, 32'h0000_1234);
    ExcValid = 1'b1; ExcInstPC = 32'h0040_0020; ExcCode = 5'b01000; tick();
    check_val("exc_over_mtc0", CP0EPC, 32'h0040_0020);

    // ERET alongside MTC0 Status: IM/IE applied, EXL forced low
    idle(); mtc0(5'd12, 3'd0, 32'h0000_AB03); EretValid = 1'b1; tick();
    check_val("eret_mtc0_status", CP0STATUS, 32'h0000_AB01);

    // asynchronous reset mid-cycle
    idle(); tick(); tick();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_val("async_rst_count", CP0COUNT, 32'd0);
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_val("resume_count", CP0COUNT, 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, 6);
        bus.WAddr = atab[k]; bus.WSel = stab[k];
      end else begin
        bus.WAddr = 5'($urandom); bus.WSel = 3'($urandom);
      end
      bus.WE = ($urandom_range(0, 2) == 0);
      bus.WData = (k == 0 && $urandom_range(0, 1) == 0) ? m_compare - 32'($urandom_range(0, 3)) : $urandom;
      k = $urandom_range(0, 6);
      if ($urandom_range(0, 4) != 0) begin
        bus.RAddr = atab[k]; bus.RSel = stab[k];
      end else begin
        bus.RAddr = 5'($urandom); bus.RSel = 3'($urandom);
      end
      HwInt = 6'($urandom);
      ExcValid = ($urandom_range(0, 9) == 0);
      ExcCode = 5'($urandom);
      ExcInstPC = {$urandom} & 32'hFFFF_FFFC;
      ExcDelay = 1'($urandom);
      EretValid = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS32 core. Holds Count, Compare, Status, Cause, EPC and EBase, and services MTC0/MFC0 from the pipeline. Records exception entry and ERET, latches hardware and timer interrupt requests, and continuously drives the CP0 contents consumed by the exception/flush controller.

## Interface

Parameters:
- PRID_VALUE, 32'h0001_8000, constant returned for PRId (reg 15, sel 0).
- EBASE_RESET, 32'h8000_0000, reset value of EBase (reg 15, sel 1).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 forces all registers to reset values immediately.
- WE  in  1  MTC0 write enable.
- WAddr  in  5  MTC0 register number.
- WSel  in  3  MTC0 select.
- WData  in  32  MTC0 write data.
- RAddr  in  5  MFC0 register number.
- RSel  in  3  MFC0 select.
- RData  out  32  MFC0 read data, combinational from current register state (no write bypass).
- HwInt  in  6  hardware interrupt lines, sampled every cycle into Cause.IP[7:2].
- ExcValid  in  1  exception taken this cycle.
- ExcCode  in  5  exception code (00000 Int, 01000 Sys).
- ExcInstPC  in  32  PC of the excepting instruction.
- ExcDelay  in  1  excepting instruction is in a delay slot.
- EretValid  in  1  ERET committing this cycle.
- CP0EBASE, CP0STATUS, CP0CAUSE, CP0EPC  out  32 each  current register contents.
- CP0COUNT, CP0COMPARE  out  32 each  current timer registers.
- IntPending  out  1  |(Cause[15:8] & Status[15:8]) & Status[0] & ~Status[1].

## Operation

- Map: Count=9/0, Compare=11/0, Status=12/0, Cause=13/0, EPC=14/0, PRId=15/0, EBase=15/1. Unmapped reads return 0; unmapped writes are ignored.
- Writable masks: Status [15:8] IM, [1] EXL, [0] IE, all other bits read 0; Cause only [9:8] (software IP) writable; EBase only [29:12] writable, [31]=1, [30]=0, [11:0]=0; EPC, Count and Compare are fully writable.
- Cause[15:10] <= HwInt every cycle, except Cause[15] = HwInt[5] | TimerPend.
- Count increments by 1 per cycle, wrapping from 0xFFFF_FFFF to 0. An MTC0 to Count loads WData in place of the increment.
- TimerPend sets on the edge where the new Count equals Compare, and clears on any MTC0 to Compare. If set and clear coincide, the clear wins.
- Exception entry (ExcValid=1):
  - If Status.EXL=0: EPC <= ExcDelay ? ExcInstPC-4 : ExcInstPC, and Cause[31] (BD) <= ExcDelay.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Always: Cause[6:2] <= ExcCode and Status.EXL <= 1.
- ERET (EretValid=1, ExcValid=0): Status.EXL <= 0. All other fields are unchanged.
- Priority: ExcValid > EretValid > MTC0.
  - ExcValid suppresses the MTC0 write in the same cycle. Count still increments and HwInt is still sampled.
  - An MTC0 to Status alongside EretValid applies IM/IE from WData, with EXL forced to 0.

## Timing

- Reset values: Status 0, Cause 0, EPC 0, Count 0, Compare 0, TimerPend 0, EBase EBASE_RESET.
- With those values all outputs read 0 except CP0EBASE = 0x8000_0000; IntPending = 0.
- MTC0, exception and ERET updates appear on outputs one cycle after the capturing edge.
- MFC0 has zero-cycle latency. A read of a register written in the same cycle returns the old value.
- HwInt reaches Cause one edge after assertion. IntPending follows combinationally.
- Timer interrupt: with Compare=C written, Cause[15] is 1 the cycle after Count becomes C.
- Reset asserted mid-operation takes effect immediately, asynchronously. Counting resumes on the first edge after rst returns to 1.

## Test plan

- Reset: hold rst=0, then release. Expect Status=0, Cause=0, EPC=0, EBase=0x8000_0000, Count=1 after the first edge.
- MTC0 Status 0xFFFF_FFFF, then MFC0 12/0. Expect 0x0000_FF03. MTC0 EBase 0xFFFF_FFFF, then read 15/1. Expect 0xBFFF_F000.
- Exception with ExcDelay=1, ExcInstPC=0x8000_0104, ExcCode=01000. Expect EPC=0x8000_0100, Cause[31]=1, Cause[6:2]=01000, EXL=1. Repeat with EXL=1: EPC stays 0x8000_0100. ERET: EXL=0.
- Status=0x0000_1001 and HwInt[2]=1. Expect Cause[12]=1 and IntPending=1. Set EXL: IntPending=0.
- Count=0xFFFF_FFFD, Compare=0x0000_0001. Expect Count to wrap through 0, and Cause[15]=1 the cycle after Count=1. MTC0 Compare clears it.
- ExcValid together with MTC0 EPC=0x1234. Expect EPC to take the exception value, not 0x1234.
